// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: on request, writes x1..x(NUM_REGS-1) to a dump
// MMIO address, then writes a stop signature. Otherwise it passes the core MMIO bus through.
module reg_dump_ctrl #(
  parameter int          NUM_REGS      = 32,
  parameter logic [31:0] ADDR_REG_DUMP = 32'h6000_0010,
  parameter logic [31:0] ADDR_STOP_SIG = 32'h6000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dump_req_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [63:0] core_wdata_i,
  input  logic [7:0]  core_strb_i,
  output logic        core_gnt_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [63:0] rf_rdata_i,
  output logic        mmio_req_o,
  output logic        mmio_we_o,
  output logic [31:0] mmio_addr_o,
  output logic [63:0] mmio_wdata_o,
  output logic [7:0]  mmio_strb_o,
  input  logic        mmio_gnt_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      r_state, w_state_nxt;
  logic        r_pending, w_pending_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic        w_pending_eff;
  logic        w_core_idle;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_idx     <= 5'd0;
      r_data    <= 64'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_idx     <= w_idx_nxt;
      r_data    <= w_data_nxt;
    end
  end

  // A request pulse counts in the cycle it arrives; the dump waits only for the core bus to go idle.
  assign w_pending_eff = r_pending | dump_req_i;
  assign w_core_idle   = !core_req_i || mmio_gnt_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_idx_nxt     = r_idx;
    w_data_nxt    = r_data;
    core_gnt_o    = 1'b0;
    rf_raddr_o    = 5'd0;
    mmio_req_o    = 1'b0;
    mmio_we_o     = 1'b0;
    mmio_addr_o   = 32'd0;
    mmio_wdata_o  = 64'd0;
    mmio_strb_o   = 8'd0;
    busy_o        = 1'b0;
    done_o        = 1'b0;

    case (r_state)
      IDLE: begin
        mmio_req_o    = core_req_i;
        mmio_we_o     = core_we_i;
        mmio_addr_o   = core_addr_i;
        mmio_wdata_o  = core_wdata_i;
        mmio_strb_o   = core_strb_i;
        core_gnt_o    = mmio_gnt_i;
        w_pending_nxt = w_pending_eff;
        if (w_pending_eff && w_core_idle) begin
          w_state_nxt   = READ;
          w_pending_nxt = 1'b0;
          w_idx_nxt     = 5'd1;
        end
      end
      READ: begin
        busy_o      = 1'b1;
        rf_raddr_o  = r_idx;
        w_state_nxt = LATCH;
      end
      LATCH: begin
        busy_o      = 1'b1;
        w_data_nxt  = rf_rdata_i;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        busy_o       = 1'b1;
        mmio_req_o   = 1'b1;
        mmio_we_o    = 1'b1;
        mmio_addr_o  = ADDR_REG_DUMP;
        mmio_wdata_o = r_data;
        mmio_strb_o  = 8'hFF;
        if (mmio_gnt_i) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_state_nxt = READ;
          end
        end
      end
      STOP: begin
        busy_o      = 1'b1;
        mmio_req_o  = 1'b1;
        mmio_we_o   = 1'b1;
        mmio_addr_o = ADDR_STOP_SIG;
        mmio_strb_o = 8'hFF;
        if (mmio_gnt_i) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: directed scenarios with randomized bus traffic, register
// contents and grants, checked against an expected write list built from the dump rules.
module tb_reg_dump_ctrl;

  localparam int          NUM_REGS = 32;
  localparam logic [31:0] A_DUMP   = 32'h6000_0010;
  localparam logic [31:0] A_STOP   = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        dump_req_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [31:0] core_addr_i;
  logic [63:0] core_wdata_i;
  logic [7:0]  core_strb_i;
  logic        core_gnt_o;
  logic [4:0]  rf_raddr_o;
  logic [63:0] rf_rdata_i;
  logic        mmio_req_o;
  logic        mmio_we_o;
  logic [31:0] mmio_addr_o;
  logic [63:0] mmio_wdata_o;
  logic [7:0]  mmio_strb_o;
  logic        mmio_gnt_i;
  logic        busy_o;
  logic        done_o;

  reg_dump_ctrl #(
    .NUM_REGS     (NUM_REGS),
    .ADDR_REG_DUMP(A_DUMP),
    .ADDR_STOP_SIG(A_STOP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .dump_req_i  (dump_req_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_addr_i (core_addr_i),
    .core_wdata_i(core_wdata_i),
    .core_strb_i (core_strb_i),
    .core_gnt_o  (core_gnt_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .mmio_req_o  (mmio_req_o),
    .mmio_we_o   (mmio_we_o),
    .mmio_addr_o (mmio_addr_o),
    .mmio_wdata_o(mmio_wdata_o),
    .mmio_strb_o (mmio_strb_o),
    .mmio_gnt_i  (mmio_gnt_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #10 clk = ~clk;

  // Register file: synchronous read, contents are rf_key + register number.
  logic [63:0] rf_key;
  always @(posedge clk) rf_rdata_i <= rf_key + 64'(rf_raddr_o);

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } xfer_t;

  xfer_t       got[$];
  int          checks   = 0;
  int          failures = 0;
  int          leak     = 0;
  int          bad_we   = 0;
  int          gnt_mode = 0;
  logic        gnt_manual = 1'b0;
  int          hold_cnt = 0;
  bit          core_rand = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  logic        s_req, s_we, s_gnt, s_core_gnt, s_busy, s_done;
  logic [31:0] s_addr;
  logic [63:0] s_wdata;
  logic [7:0]  s_strb;
  logic [4:0]  s_raddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, pick a grant, sample and monitor, then cross the edge.
  task automatic step();
    if (core_rand) begin
      core_req_i   = 1'($urandom_range(0, 1));
      core_we_i    = 1'($urandom_range(0, 1));
      core_addr_i  = $urandom;
      core_wdata_i = {$urandom, $urandom};
      core_strb_i  = 8'($urandom);
    end
    #1;
    case (gnt_mode)
      0: mmio_gnt_i = 1'b1;
      1: mmio_gnt_i = ($urandom_range(0, 3) != 0);
      2: begin
        if (busy_o && mmio_req_o && mmio_wdata_o == rf_key + 64'd7 && hold_cnt < 4) begin
          mmio_gnt_i = 1'b0;
          hold_cnt++;
        end else begin
          mmio_gnt_i = 1'b1;
        end
      end
      default: mmio_gnt_i = gnt_manual;
    endcase
    #1;
    s_req = mmio_req_o;  s_we = mmio_we_o;  s_addr = mmio_addr_o;  s_wdata = mmio_wdata_o;
    s_strb = mmio_strb_o;  s_gnt = mmio_gnt_i;  s_core_gnt = core_gnt_o;
    s_busy = busy_o;  s_done = done_o;  s_raddr = rf_raddr_o;
    if (busy_o && core_gnt_o) leak++;
    if (!busy_o && rf_raddr_o != 5'd0) leak++;
    if (done_o && (mmio_req_o || core_gnt_o || busy_o)) leak++;
    if (!busy_o && !done_o &&
        ({mmio_req_o, mmio_we_o, mmio_addr_o, mmio_wdata_o, mmio_strb_o, core_gnt_o} !==
         {core_req_i, core_we_i, core_addr_i, core_wdata_i, core_strb_i, mmio_gnt_i})) leak++;
    if ((busy_o || done_o) && !mmio_req_o &&
        (mmio_we_o || mmio_addr_o != 32'd0 || mmio_wdata_o != 64'd0 || mmio_strb_o != 8'd0)) leak++;
    if (busy_o && mmio_req_o) begin
      if (prev_stall) begin
        chk("hold_addr", 64'(mmio_addr_o), 64'(prev_addr));
        chk("hold_data", mmio_wdata_o, prev_data);
      end
      if (mmio_gnt_i) begin
        got.push_back('{mmio_addr_o, mmio_wdata_o});
        if (!mmio_we_o || mmio_strb_o != 8'hFF) bad_we++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_addr  = mmio_addr_o;
        prev_data  = mmio_wdata_o;
      end
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    dump_req_i = 1'b0;
    step();
    step();
    rst_ni     = 1'b1;
    got.delete();
    prev_stall = 1'b0;
    bad_we     = 0;
  endtask

  // Pulses dump_req_i for one cycle, then runs until done_o; returns cycles from the pulse.
  task automatic run_dump(input int bound, input int pulse_at, output int n);
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    n = 1;
    while (!done_o && n < bound) begin
      dump_req_i = (n == pulse_at);
      step();
      n++;
    end
    dump_req_i = 1'b0;
    chk("done_reached", 64'(done_o), 64'd1);
  endtask

  // Expected list: x1..x(NUM_REGS-1) to the dump address in order, then one stop write.
  task automatic check_dump(input string tag);
    chk($sformatf("%s_count", tag), 64'(got.size()), 64'(NUM_REGS));
    for (int i = 0; i < got.size() && i < NUM_REGS; i++) begin
      logic [31:0] ea;
      logic [63:0] ed;
      ea = (i < NUM_REGS - 1) ? A_DUMP : A_STOP;
      ed = (i < NUM_REGS - 1) ? rf_key + 64'(i + 1) : 64'd0;
      chk($sformatf("%s_addr[%0d]", tag, i), 64'(got[i].addr), 64'(ea));
      chk($sformatf("%s_data[%0d]", tag, i), got[i].data, ed);
    end
    chk($sformatf("%s_we_strb", tag), 64'(bad_we), 64'd0);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0;  dump_req_i = 1'b0;  mmio_gnt_i = 1'b0;
    core_req_i = 1'b0;  core_we_i = 1'b0;  core_addr_i = 32'd0;
    core_wdata_i = 64'd0;  core_strb_i = 8'd0;  rf_key = 64'h100;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    step();
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_raddr", 64'(s_raddr), 64'd0);
    chk("rst_req", 64'(s_req), 64'd0);

    // Idle pass-through, directed then random
    core_req_i = 1'b1;  core_we_i = 1'b1;  core_addr_i = 32'h6000_0020;
    core_wdata_i = 64'h1234;  core_strb_i = 8'hFF;
    step();
    chk("pt_req", 64'(s_req), 64'd1);
    chk("pt_we", 64'(s_we), 64'd1);
    chk("pt_addr", 64'(s_addr), 64'h6000_0020);
    chk("pt_wdata", s_wdata, 64'h1234);
    chk("pt_strb", 64'(s_strb), 64'hFF);
    chk("pt_gnt", 64'(s_core_gnt), 64'd1);
    chk("pt_busy", 64'(s_busy), 64'd0);
    gnt_mode = 1;
    for (int i = 0; i < 4; i++) begin
      core_req_i = 1'b1;  core_we_i = 1'($urandom_range(0, 1));  core_addr_i = $urandom;
      core_wdata_i = {$urandom, $urandom};  core_strb_i = 8'($urandom);
      step();
      chk("ptr_addr", 64'(s_addr), 64'(core_addr_i));
      chk("ptr_wdata", s_wdata, core_wdata_i);
      chk("ptr_gnt", 64'(s_core_gnt), 64'(s_gnt));
    end

    // Full dump with grant tied high; extra request pulse while in WRITE of x4
    gnt_mode = 0;  core_rand = 1'b1;  rf_key = 64'h100;
    do_reset();
    run_dump(400, 12, n);
    chk("full_latency", 64'(n), 64'd95);
    check_dump("full");
    for (int i = 0; i < 6; i++) begin
      dump_req_i = (i == 1);
      step();
    end
    dump_req_i = 1'b0;
    chk("done_sticky", 64'(s_done), 64'd1);
    chk("done_busy", 64'(s_busy), 64'd0);
    chk("done_no_more_writes", 64'(got.size()), 64'(NUM_REGS));

    // Backpressure on the x7 write for four cycles
    gnt_mode = 2;  hold_cnt = 0;  rf_key = 64'h100;
    do_reset();
    run_dump(400, -1, n);
    chk("bp_hold_cycles", 64'(hold_cnt), 64'd4);
    chk("bp_latency", 64'(n), 64'd99);
    check_dump("bp");

    // Collision with an outstanding core transfer
    gnt_mode = 3;  gnt_manual = 1'b0;  core_rand = 1'b0;  rf_key = {$urandom, $urandom};
    do_reset();
    core_req_i = 1'b1;  core_we_i = 1'b1;  core_addr_i = 32'h6000_0040;
    core_wdata_i = 64'hCAFE;  core_strb_i = 8'h0F;
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    chk("col_wait0_gnt", 64'(s_core_gnt), 64'd0);
    step();
    chk("col_wait1_busy", 64'(s_busy), 64'd0);
    gnt_manual = 1'b1;
    step();
    chk("col_core_gnt", 64'(s_core_gnt), 64'd1);
    chk("col_core_busy", 64'(s_busy), 64'd0);
    chk("col_read_busy", 64'(busy_o), 64'd1);
    chk("col_read_raddr", 64'(rf_raddr_o), 64'd1);
    chk("col_no_core_gnt", 64'(core_gnt_o), 64'd0);
    gnt_mode = 0;
    n = 0;
    while (!done_o && n < 400) begin
      step();
      n++;
    end
    chk("col_done", 64'(done_o), 64'd1);
    check_dump("col");

    // Reset while the x15 write is pending, then a fresh dump
    gnt_mode = 0;  core_rand = 1'b1;  rf_key = {$urandom, $urandom};
    do_reset();
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    n = 0;
    while (!(busy_o && mmio_req_o && mmio_addr_o == A_DUMP && mmio_wdata_o == rf_key + 64'd15) && n < 400) begin
      step();
      n++;
    end
    chk("mid_reached_x15", 64'(mmio_wdata_o), rf_key + 64'd15);
    chk("mid_prior_writes", 64'(got.size()), 64'd14);
    gnt_mode = 3;  gnt_manual = 1'b0;  rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("mid_busy", 64'(busy_o), 64'd0);
    chk("mid_done", 64'(done_o), 64'd0);
    chk("mid_passthru", 64'(mmio_addr_o), 64'(core_addr_i));
    got.delete();
    bad_we = 0;
    gnt_mode = 0;
    run_dump(400, -1, n);
    check_dump("restart");

    // Random grants and random register contents
    gnt_mode = 1;  rf_key = {$urandom, $urandom};
    do_reset();
    run_dump(2000, 40, n);
    check_dump("rand");

    chk("bus_rules", 64'(leak), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
